// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and limits for the digital clock timekeeping block
package clock_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    localparam int SEC_MAX = 59;
    localparam int MIN_MAX = 59;
    localparam int HR_MAX  = 23;

endpackage

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - two-digit BCD modulo counter wrapping MAX -> 00 with a wrap carry
module bcd_mod_counter
    import clock_pkg::*;
#(
    parameter int MAX = 59
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic load_zero,
    output bcd_t val_t,
    output bcd_t val_u,
    output logic carry_out
);

    localparam bcd_t MAX_T = bcd_t'(MAX / 10);
    localparam bcd_t MAX_U = bcd_t'(MAX % 10);

    bcd_t t_q, t_d;
    bcd_t u_q, u_d;
    logic at_max;

    assign at_max    = (t_q == MAX_T) && (u_q == MAX_U);
    // Combinational carry so a chain of counters ripples within one clock.
    assign carry_out = en & ~load_zero & at_max;
    assign val_t     = t_q;
    assign val_u     = u_q;

    // Next value: clear wins over increment; units roll into tens at 9.
    always_comb begin
        t_d = t_q;
        u_d = u_q;
        if (load_zero) begin
            t_d = '0;
            u_d = '0;
        end else if (en) begin
            if (at_max) begin
                t_d = '0;
                u_d = '0;
            end else if (u_q == 4'd9) begin
                t_d = t_q + 4'd1;
                u_d = '0;
            end else begin
                u_d = u_q + 4'd1;
            end
        end
    end

    // Digit registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            t_q <= '0;
            u_q <= '0;
        end else begin
            t_q <= t_d;
            u_q <= u_d;
        end
    end

endmodule

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - HH:MM:SS timekeeping with button-driven set-mode FSM
module clock_time_ctrl
    import clock_pkg::*;
#(
    parameter int REPEAT_DLY = 5,
    parameter int BLINK_DIV  = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       tick_1hz,
    input  logic       tick_10hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hh_t,
    output logic [3:0] hh_u,
    output logic [3:0] mm_t,
    output logic [3:0] mm_u,
    output logic [3:0] ss_t,
    output logic [3:0] ss_u,
    output logic [1:0] mode,
    output logic       blink
);

    localparam logic [3:0] RPT_MAX  = 4'(REPEAT_DLY);
    localparam logic [3:0] BLK_LAST = 4'(BLINK_DIV - 1);

    mode_e      mode_q, mode_d;
    logic       smp_mode_q, smp_mode_d, prev_mode_q, prev_mode_d, arm_mode_q, arm_mode_d;
    logic       smp_inc_q, smp_inc_d, prev_inc_q, prev_inc_d, arm_inc_q, arm_inc_d;
    logic [3:0] rpt_q, rpt_d;
    logic [3:0] blk_cnt_q, blk_cnt_d;
    logic       blink_q, blink_d;

    logic       press_mode, press_inc, rpt_ev, inc_apply, in_run;
    logic       ss_en, mm_en, hh_en, ss_clear, ss_carry, mm_carry;

    // Button sampler; arm_* stays low until the button is seen released,
    // so a button held through reset never produces a press.
    always_comb begin
        smp_mode_d  = smp_mode_q;
        prev_mode_d = prev_mode_q;
        arm_mode_d  = arm_mode_q;
        smp_inc_d   = smp_inc_q;
        prev_inc_d  = prev_inc_q;
        arm_inc_d   = arm_inc_q;
        if (tick_10hz) begin
            smp_mode_d  = btn_mode;
            prev_mode_d = smp_mode_q;
            arm_mode_d  = arm_mode_q | ~btn_mode;
            smp_inc_d   = btn_inc;
            prev_inc_d  = smp_inc_q;
            arm_inc_d   = arm_inc_q | ~btn_inc;
        end
    end

    assign press_mode = tick_10hz & arm_mode_q & smp_mode_d & ~prev_mode_d;
    assign press_inc  = tick_10hz & arm_inc_q & smp_inc_d & ~prev_inc_d;
    assign in_run     = (mode_q == MODE_RUN);

    // Auto-repeat: count held samples, then emit one inc per sample once saturated.
    always_comb begin
        rpt_d  = rpt_q;
        rpt_ev = 1'b0;
        if (press_mode) begin
            rpt_d = '0;
        end else if (tick_10hz) begin
            if (!(smp_inc_d && arm_inc_q)) begin
                rpt_d = '0;
            end else if (rpt_q == RPT_MAX) begin
                rpt_ev = 1'b1;
            end else begin
                rpt_d = rpt_q + 4'd1;
            end
        end
    end

    // A mode change in the same sample swallows the inc.
    assign inc_apply = (press_inc | rpt_ev) & ~press_mode & ~in_run;

    // Mode sequencing RUN -> SET_HR -> SET_MIN -> RUN.
    always_comb begin
        mode_d = mode_q;
        if (press_mode) begin
            case (mode_q)
                MODE_RUN:    mode_d = MODE_SET_HR;
                MODE_SET_HR: mode_d = MODE_SET_MIN;
                default:     mode_d = MODE_RUN;
            endcase
        end
    end

    // Blink phase: held on in RUN and restarted on mode change or edit.
    always_comb begin
        blink_d   = blink_q;
        blk_cnt_d = blk_cnt_q;
        if (press_mode || in_run || inc_apply) begin
            blink_d   = 1'b1;
            blk_cnt_d = '0;
        end else if (tick_10hz) begin
            if (blk_cnt_q == BLK_LAST) begin
                blink_d   = ~blink_q;
                blk_cnt_d = '0;
            end else begin
                blk_cnt_d = blk_cnt_q + 4'd1;
            end
        end
    end

    assign ss_en    = in_run & tick_1hz;
    assign mm_en    = in_run ? ss_carry : ((mode_q == MODE_SET_MIN) & inc_apply);
    assign hh_en    = in_run ? mm_carry : ((mode_q == MODE_SET_HR) & inc_apply);
    assign ss_clear = press_mode & (mode_q == MODE_SET_MIN);

    // Control state: mode FSM, button samples, repeat and blink counters.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            mode_q      <= MODE_RUN;
            smp_mode_q  <= 1'b0;
            prev_mode_q <= 1'b0;
            arm_mode_q  <= 1'b0;
            smp_inc_q   <= 1'b0;
            prev_inc_q  <= 1'b0;
            arm_inc_q   <= 1'b0;
            rpt_q       <= '0;
            blk_cnt_q   <= '0;
            blink_q     <= 1'b1;
        end else begin
            mode_q      <= mode_d;
            smp_mode_q  <= smp_mode_d;
            prev_mode_q <= prev_mode_d;
            arm_mode_q  <= arm_mode_d;
            smp_inc_q   <= smp_inc_d;
            prev_inc_q  <= prev_inc_d;
            arm_inc_q   <= arm_inc_d;
            rpt_q       <= rpt_d;
            blk_cnt_q   <= blk_cnt_d;
            blink_q     <= blink_d;
        end
    end

    bcd_mod_counter #(.MAX(SEC_MAX)) u_ss (
        .clk       (clk),
        .clr       (clr),
        .en        (ss_en),
        .load_zero (ss_clear),
        .val_t     (ss_t),
        .val_u     (ss_u),
        .carry_out (ss_carry)
    );

    bcd_mod_counter #(.MAX(MIN_MAX)) u_mm (
        .clk       (clk),
        .clr       (clr),
        .en        (mm_en),
        .load_zero (1'b0),
        .val_t     (mm_t),
        .val_u     (mm_u),
        .carry_out (mm_carry)
    );

    // Hours wrap without carrying anywhere, so the wrap output is left open.
    bcd_mod_counter #(.MAX(HR_MAX)) u_hh (
        .clk       (clk),
        .clr       (clr),
        .en        (hh_en),
        .load_zero (1'b0),
        .val_t     (hh_t),
        .val_u     (hh_u),
        .carry_out ()
    );

    assign mode  = mode_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - self-checking bench for clock_time_ctrl
module tb_clock_time_ctrl;

    localparam int REPEAT_DLY = 5;
    localparam int BLINK_DIV  = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       tick_10hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] hh_t, hh_u, mm_t, mm_u, ss_t, ss_u;
    logic [1:0] mode;
    logic       blink;

    int n_assert = 0;
    int n_fail   = 0;

    clock_time_ctrl #(.REPEAT_DLY(REPEAT_DLY), .BLINK_DIV(BLINK_DIV)) dut (
        .clk       (clk),
        .clr       (clr),
        .tick_1hz  (tick_1hz),
        .tick_10hz (tick_10hz),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .hh_t      (hh_t),
        .hh_u      (hh_u),
        .mm_t      (mm_t),
        .mm_u      (mm_u),
        .ss_t      (ss_t),
        .ss_u      (ss_u),
        .mode      (mode),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    // Model: time as seconds-of-day, button history, held-sample run, blink phase.
    int m_tod, m_mode, m_bn, m_held;
    bit m_smp_mode, m_smp_inc, m_arm_mode, m_arm_inc;

    always @(posedge clk or posedge clr) begin : model
        bit pm, pi, rpt, inc;
        int old_mode, h, m, s;
        if (clr) begin
            m_tod = 0; m_mode = 0; m_bn = 0; m_held = 0;
            m_smp_mode = 0; m_smp_inc = 0; m_arm_mode = 0; m_arm_inc = 0;
        end else begin
            old_mode = m_mode;
            pm = 0; pi = 0; rpt = 0;
            if (tick_10hz) begin
                pm = btn_mode && !m_smp_mode && m_arm_mode;
                pi = btn_inc && !m_smp_inc && m_arm_inc;
                if (pm || !(btn_inc && m_arm_inc)) m_held = 0;
                else begin
                    m_held++;
                    rpt = (m_held > REPEAT_DLY);
                end
                if (!btn_mode) m_arm_mode = 1;
                if (!btn_inc) m_arm_inc = 1;
                m_smp_mode = btn_mode;
                m_smp_inc  = btn_inc;
            end
            inc = (pi || rpt) && !pm && (old_mode != 0);
            h = m_tod / 3600; m = (m_tod / 60) % 60; s = m_tod % 60;
            if (old_mode == 0 && tick_1hz) m_tod = (m_tod + 1) % 86400;
            if (inc && old_mode == 1) m_tod = ((h + 1) % 24) * 3600 + m * 60 + s;
            if (inc && old_mode == 2) m_tod = h * 3600 + ((m + 1) % 60) * 60 + s;
            if (pm) begin
                if (old_mode == 2) m_tod = m_tod - (m_tod % 60);
                m_mode = (old_mode + 1) % 3;
            end
            if (pm || m_mode == 0 || inc) m_bn = 0;
            else if (tick_10hz) m_bn++;
        end
    end

    task automatic check_out(input string name, input int h, input int m, input int s,
                             input int md, input int bl);
        bit bad;
        n_assert++;
        bad = (int'(hh_t) != h / 10) || (int'(hh_u) != h % 10) ||
              (int'(mm_t) != m / 10) || (int'(mm_u) != m % 10) ||
              (int'(ss_t) != s / 10) || (int'(ss_u) != s % 10) ||
              (int'(mode) != md) || (int'(blink) != bl);
        if (bad) begin
            n_fail++;
            $display("FAIL %s: got %0d%0d:%0d%0d:%0d%0d mode=%0d blink=%0d, expected %02d:%02d:%02d mode=%0d blink=%0d",
                     name, hh_t, hh_u, mm_t, mm_u, ss_t, ss_u, mode, blink, h, m, s, md, bl);
        end
    endtask

    // Every settled cycle outside reset is compared with the model.
    always @(negedge clk) begin
        if (!clr) begin
            check_out("model", m_tod / 3600, (m_tod / 60) % 60, m_tod % 60, m_mode,
                      (m_mode == 0) ? 1 : (((m_bn / BLINK_DIV) % 2 == 0) ? 1 : 0));
        end
    end

    task automatic step(input bit t1, input bit t10);
        tick_1hz  = t1;
        tick_10hz = t10;
        @(posedge clk);
        #1;
        tick_1hz  = 1'b0;
        tick_10hz = 1'b0;
    endtask

    task automatic tick10();
        step(1'b0, 1'b1);
    endtask

    task automatic tick1();
        step(1'b1, 1'b0);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1; tick10();
        btn_mode = 1'b0; tick10();
    endtask

    task automatic press_inc();
        btn_inc = 1'b1; tick10();
        btn_inc = 1'b0; tick10();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        tick10();
    endtask

    task automatic set_time(input int h, input int m, input int s);
        press_mode();
        repeat (h) press_inc();
        press_mode();
        repeat (m) press_inc();
        press_mode();
        repeat (s) tick1();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        check_out("reset", 0, 0, 0, 0, 1);
        tick10();

        set_time(23, 59, 59);
        check_out("set_235959", 23, 59, 59, 0, 1);
        tick1();
        check_out("wrap_midnight", 0, 0, 0, 0, 1);

        do_clr();
        set_time(9, 59, 59);
        tick1();
        check_out("carry_to_10h", 10, 0, 0, 0, 1);

        do_clr();
        set_time(23, 45, 12);
        press_mode();
        press_inc();
        check_out("sethr_wrap", 0, 45, 12, 1, 1);
        tick1();
        check_out("sethr_frozen", 0, 45, 12, 1, 1);

        press_mode();
        repeat (13) press_inc();
        check_out("setmin_58", 0, 58, 12, 2, 1);
        btn_inc = 1'b1;
        repeat (8) tick10();
        btn_inc = 1'b0;
        tick10();
        check_out("auto_repeat", 0, 2, 12, 2, 1);

        press_mode();
        check_out("min_to_run", 0, 2, 0, 0, 1);

        press_mode();
        btn_mode = 1'b1; btn_inc = 1'b1;
        tick10();
        check_out("mode_wins", 0, 2, 0, 2, 1);
        btn_mode = 1'b0; btn_inc = 1'b0;
        tick10();
        tick10();
        check_out("blink_off", 0, 2, 0, 2, 0);
        repeat (2) tick10();
        check_out("blink_on", 0, 2, 0, 2, 1);

        btn_inc = 1'b1;
        repeat (3) tick10();
        clr = 1'b1;
        #1;
        check_out("clr_held", 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        tick10();
        press_mode();
        repeat (10) tick10();
        check_out("held_no_inc", 0, 0, 0, 1, 0);
        btn_inc = 1'b0;
        tick10();
        btn_inc = 1'b1;
        tick10();
        check_out("inc_after_low", 1, 0, 0, 1, 1);
        btn_inc = 1'b0;
        tick10();

        press_mode();
        press_mode();
        step(1'b1, 1'b1);
        check_out("coincide_ticks", 1, 0, 1, 0, 1);
        repeat (5) tick10();
        check_out("run_blink", 1, 0, 1, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
